// File: rtl/fpu_op_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_op_scheduler
// Queues FPU operation descriptors (opcode + four operand base addresses)
// and dispatches them one at a time to a bank of go/done op units. Exactly
// one unit runs at any time. Also detects bad opcodes, hung units and units
// that already report done before they are started.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous, active-high reset
//   cmd_valid_i    descriptor present
//   cmd_ready_o    FIFO not full; a command is accepted on valid && ready
//   cmd_opcode_i   unit select (opcode k drives unit k)
//   cmd_addr_i     {d,c,b,a} operand base addresses, a in the LSBs
//   unit_go_o      one-hot (or zero) go to the op units
//   unit_done_i    per-unit done level
//   unit_addr_o    addresses of the current op, stable while any go is high
//   busy_o         FIFO non-empty or FSM not idle
//   err_valid_o    one-cycle error pulse
//   err_code_o     1=bad opcode, 2=timeout, 3=spurious done; holds last value
//   ops_done_o     count of successfully completed ops, wraps at 2^16
// ---------------------------------------------------------------------------
module fpu_op_scheduler #(
  parameter int N_UNITS = 4,
  parameter int OP_W    = 4,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [OP_W-1:0]       cmd_opcode_i,
  input  logic [4*ADDR_W-1:0]   cmd_addr_i,
  output logic [N_UNITS-1:0]    unit_go_o,
  input  logic [N_UNITS-1:0]    unit_done_i,
  output logic [4*ADDR_W-1:0]   unit_addr_o,
  output logic                  busy_o,
  output logic                  err_valid_o,
  output logic [1:0]            err_code_o,
  output logic [15:0]           ops_done_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  // Command FIFO storage (data only, never reset)
  logic [OP_W-1:0]     fifo_op_q   [DEPTH];
  logic [4*ADDR_W-1:0] fifo_addr_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                full, empty, push, pop;

  logic [2:0]          state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [4*ADDR_W-1:0] addr_q, addr_d;
  logic [N_UNITS-1:0]  go_q, go_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [15:0]         ops_done_q, ops_done_d;

  logic                op_legal;
  logic                done_sel;
  logic [N_UNITS-1:0]  go_onehot;

  // Pointers carry an extra wrap bit: equal -> empty, differ only in MSB -> full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push  = cmd_valid_i && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  assign wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
  assign rd_ptr_d = rd_ptr_q + (pop  ? PTR_W'(1) : PTR_W'(0));

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_op_q[wr_ptr_q[PW-1:0]]   <= cmd_opcode_i;
      fifo_addr_q[wr_ptr_q[PW-1:0]] <= cmd_addr_i;
    end
  end

  // Opcode of the held descriptor; only meaningful after a pop.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      op_q <= fifo_op_q[rd_ptr_q[PW-1:0]];
    end
  end

  // Decode the held opcode. An opcode outside 0..N_UNITS-1 matches no unit,
  // so it reads done as 0 and produces no go bit.
  always_comb begin
    op_legal  = 1'b0;
    done_sel  = 1'b0;
    go_onehot = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (op_q == OP_W'(i)) begin
        op_legal     = 1'b1;
        done_sel     = unit_done_i[i];
        go_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    go_d       = go_q;
    timer_d    = timer_q;
    err_code_d = err_code_q;
    ops_done_d = ops_done_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          addr_d  = fifo_addr_q[rd_ptr_q[PW-1:0]];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!op_legal) begin
          err_code_d = 2'd1;
          state_d    = S_ERR;
        end else if (done_sel) begin
          // Unit claims done before it was started.
          err_code_d = 2'd3;
          state_d    = S_ERR;
        end else begin
          go_d    = go_onehot;
          timer_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (done_sel) begin
          go_d       = '0;
          ops_done_d = ops_done_q + 16'd1;
          state_d    = S_RELEASE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          go_d       = '0;
          err_code_d = 2'd2;
          state_d    = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RELEASE: begin
        // Wait for the unit to drop done before it can be reused.
        if (!done_sel) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        go_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_q     <= '0;
      go_q       <= '0;
      timer_q    <= '0;
      err_code_q <= 2'd0;
      ops_done_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_q     <= addr_d;
      go_q       <= go_d;
      timer_q    <= timer_d;
      err_code_q <= err_code_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign cmd_ready_o = !full;
  assign unit_go_o   = go_q;
  assign unit_addr_o = addr_q;
  assign busy_o      = !empty || (state_q != S_IDLE);
  assign err_valid_o = (state_q == S_ERR);
  assign err_code_o  = err_code_q;
  assign ops_done_o  = ops_done_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
module tb_fpu_op_scheduler;

  localparam int N_UNITS = 4;
  localparam int OP_W    = 4;
  localparam int ADDR_W  = 16;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [OP_W-1:0]      cmd_opcode = '0;
  logic [4*ADDR_W-1:0]  cmd_addr = '0;
  logic [N_UNITS-1:0]   unit_go;
  logic [N_UNITS-1:0]   unit_done = '0;
  logic [4*ADDR_W-1:0]  unit_addr;
  logic                 busy;
  logic                 err_valid;
  logic [1:0]           err_code;
  logic [15:0]          ops_done;

  fpu_op_scheduler #(
    .N_UNITS(N_UNITS), .OP_W(OP_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_opcode_i(cmd_opcode), .cmd_addr_i(cmd_addr),
    .unit_go_o(unit_go), .unit_done_i(unit_done), .unit_addr_o(unit_addr),
    .busy_o(busy), .err_valid_o(err_valid), .err_code_o(err_code),
    .ops_done_o(ops_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard of expected go launches / error pulses, in order.
  typedef struct packed {
    logic                is_err;
    logic [N_UNITS-1:0]  go;
    logic [4*ADDR_W-1:0] addr;
    logic [1:0]          code;
  } exp_t;
  exp_t exp_q[$];

  function automatic void exp_go(input logic [OP_W-1:0] op, input logic [4*ADDR_W-1:0] a);
    exp_t e;
    e.is_err = 1'b0;
    e.go     = N_UNITS'(1) << op;
    e.addr   = a;
    e.code   = 2'd0;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1;
    e.go     = '0;
    e.addr   = '0;
    e.code   = c;
    exp_q.push_back(e);
  endfunction

  // Monitor: a go rising from zero or an error pulse is one DUT event.
  logic [N_UNITS-1:0] prev_go = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_go = '0;
    end else begin
      if ((prev_go == '0 && unit_go != '0) || err_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: go=0x%0h err_valid=%0d code=%0d, expected no event",
                   unit_go, err_valid, err_code);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 64'(err_valid), 64'(e.is_err));
          if (e.is_err) begin
            check("err_code", 64'(err_code), 64'(e.code));
          end else begin
            check("go_vector", 64'(unit_go), 64'(e.go));
            check("go_addr", 64'(unit_addr), 64'(e.addr));
          end
        end
      end
      prev_go = unit_go;
    end
  end

  // Behavioural op units: done rises lat cycles after go rises (lat=0: never),
  // stays high hold cycles after go drops; force_hi pins done high.
  int   lat      [N_UNITS];
  int   hold     [N_UNITS];
  logic force_hi [N_UNITS];
  int   run_cnt  [N_UNITS];
  int   hold_cnt [N_UNITS];

  always @(negedge clk) begin
    for (int k = 0; k < N_UNITS; k++) begin
      if (rst) begin
        run_cnt[k]   = 0;
        hold_cnt[k]  = 0;
        unit_done[k] = force_hi[k];
      end else if (force_hi[k]) begin
        unit_done[k] = 1'b1;
      end else if (unit_go[k]) begin
        run_cnt[k]  = run_cnt[k] + 1;
        hold_cnt[k] = 0;
        if (lat[k] != 0 && run_cnt[k] >= lat[k]) unit_done[k] = 1'b1;
      end else begin
        run_cnt[k] = 0;
        if (unit_done[k]) begin
          if (hold_cnt[k] >= hold[k]) unit_done[k] = 1'b0;
          else hold_cnt[k] = hold_cnt[k] + 1;
        end
      end
    end
  end

  // Called #1 after a rising edge; the command is presented for one edge.
  task automatic push(input logic [OP_W-1:0] op, input logic [4*ADDR_W-1:0] a, output bit acc);
    cmd_opcode = op;
    cmd_addr   = a;
    cmd_valid  = 1'b1;
    acc        = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_go(input string name, input int maxc);
    int n = 0;
    @(negedge clk);
    while (unit_go == '0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(unit_go != '0), 64'd1);
  endtask

  // Counts consecutive sampled cycles with go high, starting at a cycle where go is high.
  task automatic go_len(output int n);
    n = 0;
    while (unit_go != '0 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    logic [15:0] base;
    for (int k = 0; k < N_UNITS; k++) begin
      lat[k] = 0; hold[k] = 0; force_hi[k] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_go", 64'(unit_go), 64'd0);
    check("rst_addr", 64'(unit_addr), 64'd0);
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_ops_done", 64'(ops_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;

    // Async reset in the middle of RUN on unit 1, with a second command queued
    lat[1] = 0;
    push(4'd1, 64'h1111_2222_3333_4444, acc);
    exp_go(4'd1, 64'h1111_2222_3333_4444);
    push(4'd2, 64'h5555_6666_7777_8888, acc);
    wait_go("midrun_go_seen", 10);
    repeat (3) @(negedge clk);
    check("midrun_go_before", 64'(unit_go), 64'h2);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_go", 64'(unit_go), 64'd0);
    check("midrun_rst_busy", 64'(busy), 64'd0);
    check("midrun_rst_ready", 64'(cmd_ready), 64'd1);
    check("midrun_rst_addr", 64'(unit_addr), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrun_sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("midrun_lost_cmd", 64'(unit_go), 64'd0);
    @(posedge clk);
    #1;

    // Single op on unit 2, done after 10 go cycles
    lat[2] = 10;
    push(4'd2, {16'd4, 16'd3, 16'd2, 16'd1}, acc);
    exp_go(4'd2, {16'd4, 16'd3, 16'd2, 16'd1});
    @(negedge clk);
    @(negedge clk);
    check("single_go_at_E1", 64'(unit_go), 64'd0);
    @(negedge clk);
    check("single_go_at_E2", 64'(unit_go), 64'h4);
    go_len(n);
    check("single_go_len", 64'(n), 64'd10);
    wait_idle("single_idle", 50);
    check("single_addr", 64'(unit_addr), 64'h0004_0003_0002_0001);
    check("single_ops_done", 64'(ops_done), 64'd1);

    // Fill: unit 0 stalls on a blocker while 9 commands are offered
    lat[0] = 14; lat[1] = 3; lat[2] = 3; lat[3] = 3;
    base = ops_done;
    push(4'd0, 64'hB10C_B10C_B10C_B10C, acc);
    exp_go(4'd0, 64'hB10C_B10C_B10C_B10C);
    wait_go("fill_blocker_go", 10);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      push(OP_W'(i % 4), {48'h0, 16'(16'hA000 + i)}, acc);
      check($sformatf("fill_acc_%0d", i), 64'(acc), 64'd1);
      exp_go(OP_W'(i % 4), {48'h0, 16'(16'hA000 + i)});
    end
    push(4'd1, 64'hDEAD_DEAD_DEAD_DEAD, acc);
    check("fill_9th_refused", 64'(acc), 64'd0);
    check("fill_blocker_still_running", 64'(unit_go), 64'h1);
    wait_idle("fill_idle", 400);
    check("fill_ops_done_delta", 64'(ops_done - base), 64'd9);

    // Bad opcode followed by a legal one
    lat[1] = 4;
    base = ops_done;
    push(4'd7, 64'h7777_7777_7777_7777, acc);
    exp_err(2'd1);
    push(4'd1, 64'h0101_0202_0303_0404, acc);
    exp_go(4'd1, 64'h0101_0202_0303_0404);
    wait_idle("badop_idle", 100);
    check("badop_ops_done_delta", 64'(ops_done - base), 64'd1);
    check("badop_code_held", 64'(err_code), 64'd1);

    // Hung unit 3: go for exactly TIMEOUT cycles then timeout error
    lat[3] = 0;
    base = ops_done;
    push(4'd3, 64'h3333_0000_3333_0000, acc);
    exp_go(4'd3, 64'h3333_0000_3333_0000);
    exp_err(2'd2);
    wait_go("hung_go", 10);
    go_len(n);
    check("hung_go_len", 64'(n), 64'd16);
    wait_idle("hung_idle", 50);
    check("hung_ops_done_delta", 64'(ops_done - base), 64'd0);
    check("hung_code_held", 64'(err_code), 64'd2);
    check("hung_addr_held", 64'(unit_addr), 64'h3333_0000_3333_0000);

    // Done already high at issue
    force_hi[1] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    base = ops_done;
    push(4'd1, 64'h0000_1111_0000_1111, acc);
    exp_err(2'd3);
    wait_idle("spur_idle", 50);
    check("spur_code_held", 64'(err_code), 64'd3);
    check("spur_ops_done_delta", 64'(ops_done - base), 64'd0);
    force_hi[1] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    // Done held 5 extra cycles in RELEASE delays the next go by 5
    lat[2] = 3; hold[2] = 5; lat[3] = 2;
    push(4'd2, 64'h2222_2222_2222_2222, acc);
    exp_go(4'd2, 64'h2222_2222_2222_2222);
    push(4'd3, 64'h3030_3030_3030_3030, acc);
    exp_go(4'd3, 64'h3030_3030_3030_3030);
    wait_go("rel_first_go", 10);
    go_len(n);
    check("rel_first_len", 64'(n), 64'd3);
    n = 0;
    while (unit_go == '0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rel_gap", 64'(n), 64'd8);
    wait_idle("rel_idle", 50);
    hold[2] = 0;

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
